// File: rtl/ascii_key_decoder_pkg.sv
// Shared character-code and state tables for the keypad decoder and the LCD display driver.
package ascii_key_decoder_pkg;

    // LCD character codes: decimal digits plus the error glyph.
    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_ONE       = 8'h31;
    localparam logic [7:0] ASCII_TWO       = 8'h32;
    localparam logic [7:0] ASCII_THREE     = 8'h33;
    localparam logic [7:0] ASCII_FOUR      = 8'h34;
    localparam logic [7:0] ASCII_FIVE      = 8'h35;
    localparam logic [7:0] ASCII_SIX       = 8'h36;
    localparam logic [7:0] ASCII_SEVEN     = 8'h37;
    localparam logic [7:0] ASCII_EIGHT     = 8'h38;
    localparam logic [7:0] ASCII_NINE      = 8'h39;
    localparam logic [7:0] ASCII_ERROR     = 8'h3A;
    localparam logic [7:0] ASCII_BACKSPACE = 8'h08;

    // Entry FSM encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Classification of one received byte.
    typedef struct packed {
        logic       is_digit;
        logic       is_bksp;
        logic [3:0] digit;
    } key_class_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational classifier: one ASCII byte -> digit / backspace / other.
module ascii_digit_decode
    import ascii_key_decoder_pkg::*;
(
    input  logic [7:0] ascii_i,
    output key_class_t key_class_o
);

    // Map the byte onto the shared code table.
    always_comb begin
        // NOTE: the whole output gets a default before the case, so no path can infer a latch.
        key_class_o = '0;
        case (ascii_i)
            ASCII_ZERO, ASCII_ONE, ASCII_TWO, ASCII_THREE, ASCII_FOUR,
            ASCII_FIVE, ASCII_SIX, ASCII_SEVEN, ASCII_EIGHT, ASCII_NINE: begin
                key_class_o.is_digit = 1'b1;
                key_class_o.digit    = ascii_i[3:0];
            end
            ASCII_BACKSPACE: begin
                key_class_o.is_bksp = 1'b1;
            end
            // The error glyph is a display-only code and is never a key.
            ASCII_ERROR: begin
                key_class_o = '0;
            end
            default: begin
                key_class_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/ascii_key_decoder.sv
// Keypad receive end: accepts ASCII bytes, assembles up to four BCD digits (HH:MM),
// reports the last key, decode errors and entry timeouts.
module ascii_key_decoder
    import ascii_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2560
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ascii_in,
    input  logic        ascii_valid,
    output logic        ascii_ready,
    input  logic        buffer_clear,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic [15:0] new_time,
    output logic [2:0]  digit_count,
    output logic        buffer_full,
    output logic        decode_error,
    output logic        timeout
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [15:0]      new_time_q, new_time_d;
    logic [2:0]       count_q, count_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             decode_error_q, decode_error_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    key_class_t       key_class;
    logic             xfer;

    ascii_digit_decode u_decode (
        .ascii_i     (ascii_in),
        .key_class_o (key_class)
    );

    // Ready is dropped in reset, while the buffer is full, and while the consumer clears it.
    assign ascii_ready = !reset && (state_q != ST_FULL) && !buffer_clear;
    assign xfer        = ascii_valid && ascii_ready;

    // Next-state logic: clear beats transfer, transfer beats timeout.
    always_comb begin
        state_d        = state_q;
        new_time_d     = new_time_q;
        count_d        = count_q;
        key_d          = key_q;
        key_valid_d    = 1'b0;
        decode_error_d = 1'b0;
        timeout_d      = 1'b0;
        idle_cnt_d     = '0;

        if (buffer_clear) begin
            state_d    = ST_IDLE;
            new_time_d = '0;
            count_d    = '0;
        end else if (xfer) begin
            if (key_class.is_digit) begin
                new_time_d  = {new_time_q[11:0], key_class.digit};
                count_d     = count_q + 3'd1;
                key_d       = key_class.digit;
                key_valid_d = 1'b1;
                state_d     = (count_q == 3'd3) ? ST_FULL : ST_COLLECT;
            end else if (key_class.is_bksp) begin
                // Backspace on an empty buffer is silently dropped.
                if (count_q != 3'd0) begin
                    new_time_d = {4'h0, new_time_q[15:4]};
                    count_d    = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end else begin
                decode_error_d = 1'b1;
            end
        end else if (state_q == ST_COLLECT) begin
            if (idle_cnt_q == CNT_LAST) begin
                timeout_d  = 1'b1;
                new_time_d = '0;
                count_d    = '0;
                state_d    = ST_IDLE;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    // State, buffer, idle counter and pulse registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q        <= ST_IDLE;
            new_time_q     <= '0;
            count_q        <= '0;
            key_q          <= '0;
            key_valid_q    <= 1'b0;
            decode_error_q <= 1'b0;
            timeout_q      <= 1'b0;
            idle_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            new_time_q     <= new_time_d;
            count_q        <= count_d;
            key_q          <= key_d;
            key_valid_q    <= key_valid_d;
            decode_error_q <= decode_error_d;
            timeout_q      <= timeout_d;
            idle_cnt_q     <= idle_cnt_d;
        end
    end

    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign new_time     = new_time_q;
    assign digit_count  = count_q;
    assign buffer_full  = (count_q == 3'd4);
    assign decode_error = decode_error_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_ascii_key_decoder.sv
// Self-checking bench for ascii_key_decoder: directed scenarios, then random traffic,
// all compared against a digit-queue reference model.
module tb_ascii_key_decoder;

    localparam int TO = 8;

    logic        clock;
    logic        reset;
    logic [7:0]  ascii_in;
    logic        ascii_valid;
    logic        ascii_ready;
    logic        buffer_clear;
    logic [3:0]  key;
    logic        key_valid;
    logic [15:0] new_time;
    logic [2:0]  digit_count;
    logic        buffer_full;
    logic        decode_error;
    logic        timeout;

    int tests  = 0;
    int failed = 0;

    // Reference model: the digits held, oldest first, plus last key and idle time.
    int         mq[$];
    logic [3:0] m_key;
    int         m_idle;
    bit         m_kv, m_err, m_to;

    ascii_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .ascii_in     (ascii_in),
        .ascii_valid  (ascii_valid),
        .ascii_ready  (ascii_ready),
        .buffer_clear (buffer_clear),
        .key          (key),
        .key_valid    (key_valid),
        .new_time     (new_time),
        .digit_count  (digit_count),
        .buffer_full  (buffer_full),
        .decode_error (decode_error),
        .timeout      (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_time();
        int v = 0;
        foreach (mq[i]) v = v * 16 + mq[i];
        return 16'(v);
    endfunction

    task automatic compare_all();
        check("key", 32'(key), 32'(m_key));
        check("key_valid", 32'(key_valid), 32'(m_kv));
        check("new_time", 32'(new_time), 32'(model_time()));
        check("digit_count", 32'(digit_count), mq.size());
        check("buffer_full", 32'(buffer_full), 32'(mq.size() == 4));
        check("decode_error", 32'(decode_error), 32'(m_err));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    // One clock: apply inputs, check ready, advance the model, check outputs after the edge.
    task automatic step(input bit v, input logic [7:0] b, input bit clr);
        bit rdy;
        ascii_valid  = v;
        ascii_in     = b;
        buffer_clear = clr;
        #1;
        rdy = !clr && (mq.size() != 4);
        check("ascii_ready", 32'(ascii_ready), 32'(rdy));
        m_kv  = 0;
        m_err = 0;
        m_to  = 0;
        if (clr) begin
            mq.delete();
            m_idle = 0;
        end else if (v && rdy) begin
            m_idle = 0;
            if (b >= 8'h30 && b <= 8'h39) begin
                mq.push_back(int'(b) - 48);
                m_key = 4'(int'(b) - 48);
                m_kv  = 1;
            end else if (b == 8'h08) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end else begin
                m_err = 1;
            end
        end else if (mq.size() >= 1 && mq.size() <= 3) begin
            m_idle++;
            if (m_idle == TO) begin
                mq.delete();
                m_to   = 1;
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        reset        = 1'b1;
        ascii_valid  = 1'b1;
        ascii_in     = 8'h35;
        buffer_clear = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check("ready_in_reset", 32'(ascii_ready), 32'd0);
            @(posedge clock);
            #1;
            mq.delete();
            m_key  = 4'd0;
            m_idle = 0;
            m_kv   = 0;
            m_err  = 0;
            m_to   = 0;
            compare_all();
        end
        reset       = 1'b0;
        ascii_valid = 1'b0;
        #1;
        check("ready_after_reset", 32'(ascii_ready), 32'd1);
    endtask

    initial begin
        int kv_seen;
        int err_seen;
        int wait_cycles;
        bit got_to;
        logic [7:0] seq [4];

        do_reset(3);

        // Reset mid-entry with two digits held.
        step(1, 8'h31, 0);
        step(1, 8'h32, 0);
        check("mid_entry_count", 32'(digit_count), 32'd2);
        do_reset(3);

        // Four digits back-to-back fill the buffer.
        seq[0] = 8'h31; seq[1] = 8'h32; seq[2] = 8'h33; seq[3] = 8'h34;
        kv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, seq[i], 0);
            kv_seen += int'(key_valid);
        end
        check("full_time", 32'(new_time), 32'h1234);
        check("full_count", 32'(digit_count), 32'd4);
        check("full_flag", 32'(buffer_full), 32'd1);
        check("full_ready", 32'(ascii_ready), 32'd0);
        check("full_key", 32'(key), 32'd4);
        check("full_kv_pulses", kv_seen, 32'd4);

        // A fifth byte held valid is refused until buffer_clear, and clear beats it.
        for (int i = 0; i < 3; i++) step(1, 8'h35, 0);
        check("held_time", 32'(new_time), 32'h1234);
        step(1, 8'h35, 1);
        check("clear_count", 32'(digit_count), 32'd0);
        check("clear_key_kept", 32'(key), 32'd4);
        step(1, 8'h35, 0);
        check("after_clear_count", 32'(digit_count), 32'd1);
        check("after_clear_key", 32'(key), 32'd5);
        step(0, 8'h00, 1);

        // Digit then two backspaces: count 1, 0, stays 0 with no error.
        err_seen = 0;
        step(1, 8'h39, 0); err_seen += int'(decode_error);
        check("bs_count1", 32'(digit_count), 32'd1);
        step(1, 8'h08, 0); err_seen += int'(decode_error);
        check("bs_count0", 32'(digit_count), 32'd0);
        step(1, 8'h08, 0); err_seen += int'(decode_error);
        check("bs_count_stays0", 32'(digit_count), 32'd0);
        check("bs_time", 32'(new_time), 32'd0);
        check("bs_no_error", err_seen, 32'd0);
        check("bs_key", 32'(key), 32'd9);

        // Non-digit bytes raise decode_error and leave everything else alone.
        step(1, 8'h36, 0);
        err_seen = 0;
        step(1, 8'h3A, 0); err_seen += int'(decode_error);
        step(1, 8'h41, 0); err_seen += int'(decode_error);
        check("err_pulses", err_seen, 32'd2);
        check("err_time", 32'(new_time), 32'h0006);
        check("err_count", 32'(digit_count), 32'd1);
        check("err_key", 32'(key), 32'd6);
        step(0, 8'h00, 1);

        // Partial entry times out exactly TO cycles after the last transfer.
        step(1, 8'h37, 0);
        got_to      = 0;
        wait_cycles = 0;
        for (int i = 0; i < 3 * TO && !got_to; i++) begin
            step(0, 8'h00, 0);
            wait_cycles++;
            got_to = timeout;
        end
        check("timeout_seen", 32'(got_to), 32'd1);
        check("timeout_latency", wait_cycles, TO);
        check("timeout_count", 32'(digit_count), 32'd0);
        check("timeout_key", 32'(key), 32'd7);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] b;
            bit v;
            bit c;
            r = int'($urandom_range(99));
            if (r < 55)      b = 8'h30 + 8'($urandom_range(9));
            else if (r < 72) b = 8'h08;
            else if (r < 80) b = 8'h3A;
            else             b = 8'($urandom);
            v = ($urandom_range(99) < 70);
            c = ($urandom_range(99) < 4);
            step(v, b, c);
            if ($urandom_range(99) < 4) begin
                for (int k = 0; k < TO + 2; k++) step(0, 8'h00, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
